// File: rtl/hdma_if.sv
// rtl/hdma_if.sv - HDMA register, HBlank and source/VRAM bus bundle
interface hdma_if;
  logic [2:0]  reg_sel;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        hblank;
  logic        lcd_on;
  logic [15:0] dma_a;
  logic        dma_rd;
  logic [7:0]  dma_rdata;
  logic [12:0] ma;
  logic [7:0]  ma_wdata;
  logic        vram_wr;
  logic        dma_run;

  modport master (
    input  reg_sel, reg_wr, reg_rd, wdata, hblank, lcd_on, dma_rdata,
    output rdata, dma_a, dma_rd, ma, ma_wdata, vram_wr, dma_run
  );

  modport slave (
    output reg_sel, reg_wr, reg_rd, wdata, hblank, lcd_on, dma_rdata,
    input  rdata, dma_a, dma_rd, ma, ma_wdata, vram_wr, dma_run
  );
endinterface

// File: rtl/hdma_ctl.sv
// rtl/hdma_ctl.sv - block-transfer DMA into VRAM; HDMA_HBLANK_EN adds HBlank mode and cancel
module hdma_ctl #(
  parameter int BLOCK_BYTES = 16,
  parameter int LEN_W       = 7
) (
  input  logic   clk1,
  input  logic   reset,
  hdma_if.master bus
);
  localparam int         OFF_W   = $clog2(BLOCK_BYTES);
  localparam logic [7:0] LO_MASK = 8'hFF << OFF_W;

  typedef enum logic [1:0] {IDLE, WAIT_HB, RD, WR} state_t;

  state_t           state;
  logic [15:0]      src;
  logic [12:0]      dst;
  logic [LEN_W-1:0] rem_m1;
  logic             hb_mode;
  logic             cancel_req;
  logic             cancelled;
  logic [7:0]       status;

  // Addresses are block aligned, so the low source bits double as the byte-in-block counter.
  logic blk_last;
  logic ctl_wr;
  logic cancel_wr;
  logic hb_start;
  assign blk_last  = &src[OFF_W-1:0];
  assign ctl_wr    = bus.reg_wr && (bus.reg_sel == 3'd4);
  assign cancel_wr = hb_mode && ctl_wr && !bus.wdata[7];

`ifdef HDMA_HBLANK_EN
  logic hb_q;
  logic hb_rise;
  assign hb_start = bus.wdata[7];
  assign hb_rise  = bus.hblank && !hb_q && bus.lcd_on;

  always_ff @(posedge clk1) begin
    if (reset) hb_q <= 1'b0;
    else       hb_q <= bus.hblank;
  end
`else
  logic unused_hb;
  assign hb_start  = 1'b0;
  assign unused_hb = &{1'b0, bus.hblank, bus.lcd_on};
`endif

  always_ff @(posedge clk1) begin
    if (reset) begin
      state        <= IDLE;
      src          <= '0;
      dst          <= '0;
      rem_m1       <= '0;
      hb_mode      <= 1'b0;
      cancel_req   <= 1'b0;
      cancelled    <= 1'b0;
      bus.dma_a    <= '0;
      bus.dma_rd   <= 1'b0;
      bus.ma       <= '0;
      bus.ma_wdata <= '0;
      bus.vram_wr  <= 1'b0;
      bus.dma_run  <= 1'b0;
    end else begin
      bus.dma_rd  <= 1'b0;
      bus.vram_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.reg_wr) begin
            case (bus.reg_sel)
              3'd0: src[15:8] <= bus.wdata;
              3'd1: src[7:0]  <= bus.wdata & LO_MASK;
              3'd2: dst[12:8] <= bus.wdata[4:0];
              3'd3: dst[7:0]  <= bus.wdata & LO_MASK;
              3'd4: begin
                rem_m1     <= bus.wdata[LEN_W-1:0];
                hb_mode    <= hb_start;
                cancel_req <= 1'b0;
                cancelled  <= 1'b0;
                if (hb_start) begin
                  state <= WAIT_HB;
                end else begin
                  state       <= RD;
                  bus.dma_a   <= src;
                  bus.dma_rd  <= 1'b1;
                  bus.dma_run <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
`ifdef HDMA_HBLANK_EN
        WAIT_HB: begin
          if (cancel_wr) begin
            state     <= IDLE;
            cancelled <= 1'b1;
          end else if (hb_rise) begin
            state       <= RD;
            bus.dma_a   <= src;
            bus.dma_rd  <= 1'b1;
            bus.dma_run <= 1'b1;
          end
        end
`endif
        RD: begin
          if (cancel_wr) cancel_req <= 1'b1;
          state        <= WR;
          bus.ma       <= dst;
          bus.ma_wdata <= bus.dma_rdata;
          bus.vram_wr  <= 1'b1;
        end
        WR: begin
          if (cancel_wr) cancel_req <= 1'b1;
          src <= src + 16'd1;
          dst <= dst + 13'd1;
          if (!blk_last) begin
            state      <= RD;
            bus.dma_a  <= src + 16'd1;
            bus.dma_rd <= 1'b1;
          end else if (rem_m1 == '0) begin
            state       <= IDLE;
            bus.dma_run <= 1'b0;
            cancel_req  <= 1'b0;
          end else begin
            rem_m1 <= rem_m1 - 1'b1;
            if (cancel_req || cancel_wr) begin
              state       <= IDLE;
              bus.dma_run <= 1'b0;
              cancel_req  <= 1'b0;
              cancelled   <= 1'b1;
            end else if (hb_mode) begin
              state       <= WAIT_HB;
              bus.dma_run <= 1'b0;
            end else begin
              state      <= RD;
              bus.dma_a  <= src + 16'd1;
              bus.dma_rd <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    status = 8'hFF;
    if (state != IDLE) status = {1'b0, 7'(rem_m1)};
    else if (cancelled) status = {1'b1, 7'(rem_m1)};
  end

  assign bus.rdata = (bus.reg_rd && bus.reg_sel == 3'd4) ? status : 8'hFF;
endmodule

// File: tb/tb_hdma_ctl.sv
// tb/tb_hdma_ctl.sv - directed vector bench for hdma_ctl
module tb_hdma_ctl;
  logic clk1 = 1'b0;
  logic reset;
  hdma_if bus();

  hdma_ctl #(.BLOCK_BYTES(16), .LEN_W(7)) dut (.clk1(clk1), .reset(reset), .bus(bus));

  always #5 clk1 = ~clk1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  sh, sl, dh, dl, ctl;
    logic [15:0] first_a;
    logic [12:0] first_ma;
    int          bytes;
    logic [7:0]  act_status;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign bus.dma_rdata = src_byte(bus.dma_a);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] sel, input logic [7:0] d);
    @(negedge clk1);
    bus.reg_sel = sel;
    bus.wdata   = d;
    bus.reg_wr  = 1'b1;
    @(negedge clk1);
    bus.reg_wr  = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] sel, output logic [7:0] v);
    bus.reg_sel = sel;
    bus.reg_rd  = 1'b1;
    #1 v = bus.rdata;
    bus.reg_rd  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] ea, ews, fa;
    logic [12:0] em, fm;
    logic [7:0]  st;
    int rd_n, wr_n, run_n, last_wr, bad;
    wr_reg(3'd0, v.sh);
    wr_reg(3'd1, v.sl);
    wr_reg(3'd2, v.dh);
    wr_reg(3'd3, v.dl);
    wr_reg(3'd4, v.ctl);
    rd_reg(3'd4, st);
    check({tag, " active status"}, 32'(st), 32'(v.act_status));
    ea = v.first_a; ews = v.first_a; em = v.first_ma;
    fa = '0; fm = '0;
    rd_n = 0; wr_n = 0; run_n = 0; last_wr = 0; bad = 0;
    for (int k = 1; k <= 400; k++) begin
      if (!bus.dma_run) break;
      run_n++;
      if (bus.dma_rd) begin
        if (rd_n == 0) fa = bus.dma_a;
        if (bus.dma_a !== ea) bad++;
        ea++;
        rd_n++;
      end
      if (bus.vram_wr) begin
        if (wr_n == 0) fm = bus.ma;
        if (bus.ma !== em || bus.ma_wdata !== src_byte(ews)) bad++;
        em++;
        ews++;
        wr_n++;
        last_wr = k;
      end
      @(negedge clk1);
    end
    check({tag, " first dma_a"}, 32'(fa), 32'(v.first_a));
    check({tag, " first ma"}, 32'(fm), 32'(v.first_ma));
    check({tag, " reads"}, rd_n, v.bytes);
    check({tag, " writes"}, wr_n, v.bytes);
    check({tag, " run cycles"}, run_n, 2 * v.bytes);
    check({tag, " last write cycle"}, last_wr, 2 * v.bytes);
    check({tag, " bad bytes"}, bad, 0);
    rd_reg(3'd4, st);
    check({tag, " done status"}, 32'(st), 32'hFF);
  endtask

`ifdef HDMA_HBLANK_EN
  task automatic hb_pulse(input int cancel_at, output int bytes, output int first_k,
                          output logic [15:0] first_a);
    bytes = 0; first_k = 0; first_a = '0;
    @(negedge clk1);
    bus.hblank = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk1);
      if (bus.dma_rd && first_k == 0) begin
        first_k = k;
        first_a = bus.dma_a;
      end
      if (bus.vram_wr) bytes++;
      if (k == 3 || k == 12) bus.hblank = 1'b0;
      if (k == 10) bus.hblank = 1'b1;
      if (k == cancel_at) begin
        bus.reg_sel = 3'd4;
        bus.wdata   = 8'h00;
        bus.reg_wr  = 1'b1;
      end
      if (k == cancel_at + 1) bus.reg_wr = 1'b0;
    end
    bus.hblank = 1'b0;
  endtask
`endif

  initial begin
    logic [7:0]  st;
    logic [15:0] fa;
    int          b, fk, run_n, strobes;
    vec_t        r;

    vecs[0] = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h01, 16'hC000, 13'h0000, 32, 8'h01};
    vecs[1] = '{8'h12, 8'h37, 8'hFF, 8'h4F, 8'h00, 16'h1230, 13'h1F40, 16, 8'h00};
    vecs[2] = '{8'hFF, 8'hF0, 8'h1F, 8'hF0, 8'h01, 16'hFFF0, 13'h1FF0, 32, 8'h01};
`ifdef HDMA_HBLANK_EN
    vecs[3] = '{8'h40, 8'h05, 8'h03, 8'h21, 8'h02, 16'h4000, 13'h0320, 48, 8'h02};
`else
    vecs[3] = '{8'h40, 8'h05, 8'h03, 8'h21, 8'h80, 16'h4000, 13'h0320, 16, 8'h00};
`endif

    bus.reg_sel = '0; bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.wdata = '0;
    bus.hblank = 1'b0; bus.lcd_on = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk1);
    reset = 1'b0;
    @(negedge clk1);

    check("reset dma_rd", 32'(bus.dma_rd), 32'd0);
    check("reset vram_wr", 32'(bus.vram_wr), 32'd0);
    check("reset dma_run", 32'(bus.dma_run), 32'd0);
    check("reset dma_a", 32'(bus.dma_a), 32'd0);
    check("reset ma", 32'(bus.ma), 32'd0);
    check("reset ma_wdata", 32'(bus.ma_wdata), 32'd0);
    rd_reg(3'd4, st);
    check("reset status", 32'(st), 32'hFF);
    for (int s = 0; s < 4; s++) begin
      rd_reg(3'(s), st);
      check($sformatf("addr reg %0d read", s), 32'(st), 32'hFF);
    end

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    wr_reg(3'd0, 8'hC0); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h00); wr_reg(3'd3, 8'h00);
    wr_reg(3'd4, 8'h00);
    repeat (10) @(negedge clk1);
    check("byte5 dma_rd", 32'(bus.dma_rd), 32'd1);
    check("byte5 dma_a", 32'(bus.dma_a), 32'hC005);
    reset = 1'b1;
    @(negedge clk1);
    reset = 1'b0;
    check("mid reset strobes", 32'({bus.dma_rd, bus.vram_wr, bus.dma_run}), 32'd0);
    rd_reg(3'd4, st);
    check("mid reset status", 32'(st), 32'hFF);
    strobes = 0;
    repeat (4) begin
      @(negedge clk1);
      if (bus.dma_rd || bus.vram_wr || bus.dma_run) strobes++;
    end
    check("post reset quiet", strobes, 0);
    r = '{8'h20, 8'h00, 8'h01, 8'h00, 8'h00, 16'h2000, 13'h0100, 16, 8'h00};
    run_vec(r, "restart");

`ifdef HDMA_HBLANK_EN
    wr_reg(3'd0, 8'h80); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h04); wr_reg(3'd3, 8'h00);
    wr_reg(3'd4, 8'h82);
    rd_reg(3'd4, st);
    check("hb start status", 32'(st), 32'h02);
    wr_reg(3'd0, 8'h00);
    run_n = 0;
    repeat (10) begin
      @(negedge clk1);
      if (bus.dma_run) run_n++;
    end
    check("hb waits", run_n, 0);
    hb_pulse(0, b, fk, fa);
    check("hb1 bytes", b, 16);
    check("hb1 latency", fk, 1);
    check("hb1 first dma_a", 32'(fa), 32'h8000);
    rd_reg(3'd4, st);
    check("hb1 status", 32'(st), 32'h01);
    bus.lcd_on = 1'b0;
    hb_pulse(0, b, fk, fa);
    bus.lcd_on = 1'b1;
    check("hb lcd off bytes", b, 0);
    rd_reg(3'd4, st);
    check("hb lcd off status", 32'(st), 32'h01);
    hb_pulse(0, b, fk, fa);
    check("hb2 bytes", b, 16);
    check("hb2 first dma_a", 32'(fa), 32'h8010);
    rd_reg(3'd4, st);
    check("hb2 status", 32'(st), 32'h00);
    hb_pulse(0, b, fk, fa);
    check("hb3 bytes", b, 16);
    check("hb3 first dma_a", 32'(fa), 32'h8020);
    rd_reg(3'd4, st);
    check("hb3 status", 32'(st), 32'hFF);

    bus.hblank = 1'b1;
    wr_reg(3'd0, 8'h90); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h08); wr_reg(3'd3, 8'h00);
    wr_reg(3'd4, 8'h83);
    run_n = 0;
    repeat (10) begin
      @(negedge clk1);
      if (bus.dma_run) run_n++;
    end
    check("hb level high no start", run_n, 0);
    bus.hblank = 1'b0;
    hb_pulse(0, b, fk, fa);
    check("cancelA blk1 bytes", b, 16);
    rd_reg(3'd4, st);
    check("cancelA blk1 status", 32'(st), 32'h02);
    wr_reg(3'd4, 8'h00);
    rd_reg(3'd4, st);
    check("cancelA status", 32'(st), 32'h82);
    hb_pulse(0, b, fk, fa);
    check("cancelA no writes", b, 0);

    wr_reg(3'd0, 8'hA0); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h0C); wr_reg(3'd3, 8'h00);
    wr_reg(3'd4, 8'h83);
    rd_reg(3'd4, st);
    check("cancelB start status", 32'(st), 32'h03);
    hb_pulse(0, b, fk, fa);
    check("cancelB blk1 bytes", b, 16);
    hb_pulse(6, b, fk, fa);
    check("cancelB mid block bytes", b, 16);
    rd_reg(3'd4, st);
    check("cancelB status", 32'(st), 32'h81);
    hb_pulse(0, b, fk, fa);
    check("cancelB no writes", b, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hdma_ctl.md
# hdma_ctl

Parametrised block-transfer DMA controller: next generation of the OAM DMA engine. It copies CPU-programmed source ranges into VRAM in fixed-size blocks. Two modes: general-purpose (whole length at once, CPU stalled) and HBlank (one block per HBlank). Sits beside the OAM DMA on the CPU data bus and shares the external address and VRAM address muxes with it.

## Interface
Parameters:
- BLOCK_BYTES, 16: bytes per block; power of two, 2..128.
- LEN_W, 7: width of the block-count field; maximum transfer is 2^LEN_W blocks.

Ports:
- clk1  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- reg_sel  in  3  register select: 0 src hi, 1 src lo, 2 dst hi, 3 dst lo, 4 control.
- reg_wr  in  1  single-cycle register write strobe.
- reg_rd  in  1  register read enable.
- wdata  in  8  CPU write data.
- rdata  out  8  read data; 0xFF for selects 0..3; control status for select 4.
- hblank  in  1  PPU HBlank level.
- lcd_on  in  1  LCD enable.
- dma_a  out  16  source address.
- dma_rd  out  1  source read strobe.
- dma_rdata  in  8  source byte, valid by end of the cycle in which dma_rd is high.
- ma  out  13  VRAM destination address.
- ma_wdata  out  8  byte to VRAM.
- vram_wr  out  1  VRAM write strobe.
- dma_run  out  1  high while bytes move; stalls CPU.

## Operation
- Source register: 16 bits. Low log2(BLOCK_BYTES) bits are forced to 0 on write. Destination register: 13 bits. Bits 7:5 of dst hi are ignored, and the low bits are forced to 0 as for the source.
- Control write, bit7=0: start a general transfer. Bit7=1: start an HBlank transfer. Length field wdata[LEN_W-1:0] holds blocks-1.
- States:
  - IDLE -> RD on a general start.
  - IDLE -> WAIT_HB on an HBlank start.
  - WAIT_HB -> RD on a rising edge of hblank while lcd_on=1.
  - RD <-> WR, alternating once per byte.
  - After the last byte of a block: if blocks remain, general mode goes to RD and HBlank mode goes to WAIT_HB; otherwise the next state is IDLE.
- RD: dma_a=src, dma_rd=1; dma_rdata is latched at the end of the cycle.
- WR: ma=dst, ma_wdata=latched byte, vram_wr=1. After WR, src and dst each increment by 1.
- Wrap rules: src wraps 0xFFFF->0x0000. dst wraps 0x1FFF->0x0000, modulo 13 bits.
- Remaining count decrements once per completed block.
- Status read (select 4):
  - Active: {0, remaining-1}.
  - Completed: 0xFF.
  - Cancelled: {1, remaining-1}.
- Control write with bit7=0 while in HBlank mode cancels the transfer:
  - In WAIT_HB: go to IDLE on the next edge.
  - In RD/WR: finish the current block, then go to IDLE. The count is decremented for that block.
- Control write with bit7=1 while active: ignored.
- Src/dst writes while not IDLE: ignored.

## Timing
- Reset: state IDLE; src, dst and count = 0; dma_a, ma, ma_wdata = 0; dma_rd, vram_wr, dma_run = 0; status reads 0xFF.
- Reset asserted mid-transfer: IDLE on the next edge; no further strobes.
- General start: the write is in cycle N, the first RD is in cycle N+1.
- Each byte takes 2 cycles; a block takes 2*BLOCK_BYTES cycles.
- A general transfer of L blocks ends with its last WR in cycle N+2*BLOCK_BYTES*L.
- HBlank edge detect: hblank is registered internally, so the first RD follows 1 cycle after the sampled rise.
- An hblank level already high at start does not trigger; the block waits for the next rising edge.
- Rising edges of hblank during RD/WR are ignored; there is no queuing.
- dma_run = 1 exactly in RD and WR cycles.
- Status reads are combinational from registered state.

## Configuration
- HDMA_HBLANK_EN defined: both modes as above.
- Not defined:
  - WAIT_HB and the hblank/lcd_on logic are removed.
  - Control bit7 is ignored, so every start is a general transfer.
  - Cancel is not possible.
  - Status bit7 reads 0 while active and the register reads 0xFF when idle.

## Test plan
- General, BLOCK_BYTES=16, src=0xC000, dst=0x0000, len=0x01:
  - Required: 32 RD/WR pairs copy to 0x0000..0x001F over cycles N+1..N+64.
  - dma_run is high for 64 cycles.
  - Status is 0xFF afterward.
- Alignment: write src lo=0x37 and dst lo=0x4F.
  - Required: first dma_a low byte = 0x30, first ma low byte = 0x40.
  - dst hi=0xFF gives ma[12:8]=0x1F.
- Wrap: src=0xFFF0, dst=0x1FF0, len=0x01.
  - Required: dma_a goes 0xFFFF->0x0000 and ma goes 0x1FFF->0x0000 on byte 16.
- HBlank (HDMA_HBLANK_EN defined), len=0x02, lcd_on=1, three hblank pulses:
  - Required: exactly one 16-byte block per pulse.
  - Status reads 0x01, then 0x00, then 0xFF.
  - A pulse while lcd_on=0 moves nothing.
- Cancel (HDMA_HBLANK_EN defined):
  - Write 0x00 to control in WAIT_HB after 1 of 4 blocks: status reads 0x82 and there is no further vram_wr.
  - The same write mid-block: that block completes, then status reads 0x81.
- Reset at byte 5 of a general transfer:
  - Required: strobes drop the next cycle, status 0xFF.
  - A new start works normally.
